// File: rtl/c3aibadapt_sr_async_launch_bus.sv
// ---------------------------------------------------------------------------
// c3aibadapt_sr_async_launch_bus
//   Launches parallel words onto an async bus. A foreign clock domain captures
//   the bus with a 2-flop synchronizer plus a three-equal-sample check.
//   Every launched word is held unchanged for at least HOLD_CYCLES clk cycles.
//   While a hold is running, one further word can be buffered as pending.
//
// Parameters
//   DWIDTH       bus width in bits
//   RESET_VAL    reset level of every data_out bit (non-zero: all ones)
//   HOLD_CYCLES  minimum hold per launch, 1..255
//
// Ports
//   clk            launch clock
//   rst            synchronous reset, active high
//   data_in        word to launch, sampled when load=1
//   load           single-cycle launch request
//   r_launch_mode  1: a load preempts the running hold, 0: a load is buffered
//   data_out       async bus, registered, all bits change in one stage
//   busy           hold window active or pending word waiting
//   launch_done    1-cycle pulse when a hold expires with nothing left to send
//   overrun        1-cycle pulse when an unsent pending word is overwritten
// ---------------------------------------------------------------------------
module c3aibadapt_sr_async_launch_bus #(
  parameter int unsigned DWIDTH      = 2,
  parameter int unsigned RESET_VAL   = 1,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              load,
  input  logic              r_launch_mode,
  output logic [DWIDTH-1:0] data_out,
  output logic              busy,
  output logic              launch_done,
  output logic              overrun
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DWIDTH-1:0] RST_WORD = {DWIDTH{RESET_VAL != 0}};
  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [DWIDTH-1:0] pend_data_q, pend_data_d;
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;

  logic              launch;
  logic [DWIDTH-1:0] launch_word;

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    ovr_d       = 1'b0;
    launch      = 1'b0;
    launch_word = data_in;

    case (state_q)
      IDLE: begin
        // Counter parks at zero while idle
        cnt_d = '0;
        if (load) begin
          launch = 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (load) begin
            if (r_launch_mode) begin
              // Preempt: new word goes out now and restarts the hold
              launch = 1'b1;
              pend_d = 1'b0;
            end else begin
              pend_data_d = data_in;
              pend_d      = 1'b1;
              ovr_d       = pend_q;
            end
          end
        end else if (pend_q && !(load && r_launch_mode)) begin
          // Hold expired: send the buffered word; a same-cycle load refills the buffer
          launch      = 1'b1;
          launch_word = pend_data_q;
          pend_d      = load;
          if (load) begin
            pend_data_d = data_in;
          end
        end else if (load) begin
          launch = 1'b1;
          pend_d = 1'b0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      data_out_d = launch_word;
      cnt_d      = CNT_RELOAD;
      state_d    = HOLD;
    end

    busy_d = (state_d == HOLD) | pend_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      data_out_q  <= RST_WORD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign data_out    = data_out_q;
  assign busy        = busy_q;
  assign launch_done = done_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_c3aibadapt_sr_async_launch_bus.sv
// Directed bench for c3aibadapt_sr_async_launch_bus, with a slow-clock
// synchronizing monitor that logs every value it sees as stable.
module tb_c3aibadapt_sr_async_launch_bus;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] data_in = 2'b00;
  logic       load = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] data_out;
  logic       busy, done, ovr;

  // Second instance: single-cycle hold, reset level zero
  logic [1:0] data_in1 = 2'b00;
  logic       load1 = 1'b0;
  logic [1:0] data_out1;
  logic       busy1, done1, ovr1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  c3aibadapt_sr_async_launch_bus #(.DWIDTH(2), .RESET_VAL(1), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .r_launch_mode(mode),
    .data_out(data_out), .busy(busy), .launch_done(done), .overrun(ovr)
  );

  c3aibadapt_sr_async_launch_bus #(.DWIDTH(2), .RESET_VAL(0), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in1), .load(load1), .r_launch_mode(1'b0),
    .data_out(data_out1), .busy(busy1), .launch_done(done1), .overrun(ovr1)
  );

  // Far-end monitor: 2x slower clock, offset from clk edges
  logic slow_clk = 1'b0;
  initial begin
    #3;
    forever #10 slow_clk = ~slow_clk;
  end
  logic [1:0] s1 = 2'b00, s2 = 2'b00, h1 = 2'b00, h2 = 2'b00, cap_last = 2'b00;
  logic [1:0] cap_log[$];
  always @(posedge slow_clk) begin
    s1 <= data_out;
    s2 <= s1;
    h1 <= s2;
    h2 <= h1;
    if (s2 == h1 && h1 == h2 && s2 != cap_last) begin
      cap_last <= s2;
      cap_log.push_back(s2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load = 1'b0;
    load1 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    load = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (data_out !== 2'b11 || busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d got dout=%b busy=%b done=%b ovr=%b exp 11 0 0 0",
                 i, data_out, busy, done, ovr);
      end
    end
    n_checks++;
    if (data_out1 !== 2'b00 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_h1 got dout=%b busy=%b exp 00 0", data_out1, busy1);
    end
  endtask

  task automatic test_single_launch();
    logic [1:0] exp_d;
    do_reset();
    cap_log.delete();
    mode = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      load = (e == 0);
      data_in = 2'b01;
      tick();
      exp_d = 2'b01;
      n_checks++;
      if (data_out !== exp_d || busy !== (e < 8) || done !== (e == 8) || ovr !== 1'b0) begin
        n_fail++;
        $display("FAIL single e=%0d got dout=%b busy=%b done=%b ovr=%b exp %b %b %b 0",
                 e, data_out, busy, done, ovr, exp_d, e < 8, e == 8);
      end
    end
    load = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (cap_log.size() != 1 || cap_log[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL single_monitor got %0d entries first=%b exp 1 entry 01",
               cap_log.size(), (cap_log.size() > 0) ? cap_log[0] : 2'bxx);
    end
  endtask

  task automatic test_pending_overrun();
    logic [1:0] exp_d;
    do_reset();
    cap_log.delete();
    mode = 1'b0;
    for (int e = 0; e <= 17; e++) begin
      load = (e == 0 || e == 3 || e == 5);
      data_in = (e == 0) ? 2'b01 : (e == 3) ? 2'b10 : 2'b00;
      tick();
      exp_d = (e < 8) ? 2'b01 : 2'b00;
      n_checks++;
      if (data_out !== exp_d || busy !== (e < 16) || done !== (e == 16) || ovr !== (e == 5)) begin
        n_fail++;
        $display("FAIL pend_ovr e=%0d got dout=%b busy=%b done=%b ovr=%b exp %b %b %b %b",
                 e, data_out, busy, done, ovr, exp_d, e < 16, e == 16, e == 5);
      end
    end
    load = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (cap_log.size() != 2 || cap_log[0] !== 2'b01 || cap_log[1] !== 2'b00) begin
      n_fail++;
      $display("FAIL pend_monitor got %0d entries exp 2 entries 01,00", cap_log.size());
    end
  endtask

  task automatic test_preempt();
    logic [1:0] exp_d;
    do_reset();
    mode = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      load = (e == 0 || e == 3);
      data_in = (e == 0) ? 2'b01 : 2'b10;
      tick();
      exp_d = (e < 3) ? 2'b01 : 2'b10;
      n_checks++;
      if (data_out !== exp_d || busy !== (e < 11) || done !== (e == 11) || ovr !== 1'b0) begin
        n_fail++;
        $display("FAIL preempt e=%0d got dout=%b busy=%b done=%b ovr=%b exp %b %b %b 0",
                 e, data_out, busy, done, ovr, exp_d, e < 11, e == 11);
      end
    end
    load = 1'b0;
    mode = 1'b0;
  endtask

  task automatic test_load_at_expiry();
    logic [1:0] exp_d;
    do_reset();
    mode = 1'b0;
    for (int e = 0; e <= 25; e++) begin
      load = (e == 0 || e == 3 || e == 8);
      data_in = (e == 0) ? 2'b01 : (e == 3) ? 2'b10 : 2'b11;
      tick();
      exp_d = (e < 8) ? 2'b01 : (e < 16) ? 2'b10 : 2'b11;
      n_checks++;
      if (data_out !== exp_d || busy !== (e < 24) || done !== (e == 24) || ovr !== 1'b0) begin
        n_fail++;
        $display("FAIL expiry e=%0d got dout=%b busy=%b done=%b ovr=%b exp %b %b %b 0",
                 e, data_out, busy, done, ovr, exp_d, e < 24, e == 24);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    logic [1:0] exp_d;
    do_reset();
    mode = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      load = (e == 0 || e == 3);
      data_in = (e == 0) ? 2'b01 : 2'b10;
      rst = (e == 5);
      tick();
      exp_d = (e < 5) ? 2'b01 : 2'b11;
      n_checks++;
      if (data_out !== exp_d || busy !== (e < 5) || done !== 1'b0 || ovr !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid e=%0d got dout=%b busy=%b done=%b ovr=%b exp %b %b 0 0",
                 e, data_out, busy, done, ovr, exp_d, e < 5);
      end
    end
    rst = 1'b0;
    load = 1'b0;
  endtask

  task automatic test_equal_value();
    do_reset();
    mode = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      load = (e == 0);
      data_in = 2'b11;
      tick();
      n_checks++;
      if (data_out !== 2'b11 || busy !== (e < 8) || done !== (e == 8)) begin
        n_fail++;
        $display("FAIL equal e=%0d got dout=%b busy=%b done=%b exp 11 %b %b",
                 e, data_out, busy, done, e < 8, e == 8);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] vals [4];
    logic [1:0] exp_d;
    vals[0] = 2'b01;
    vals[1] = 2'b10;
    vals[2] = 2'b11;
    vals[3] = 2'b01;
    do_reset();
    for (int e = 0; e <= 5; e++) begin
      load1 = (e < 4);
      data_in1 = vals[(e < 4) ? e : 3];
      tick();
      exp_d = vals[(e < 4) ? e : 3];
      n_checks++;
      if (data_out1 !== exp_d || busy1 !== (e < 4) || done1 !== (e == 4) || ovr1 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b e=%0d got dout=%b busy=%b done=%b ovr=%b exp %b %b %b 0",
                 e, data_out1, busy1, done1, ovr1, exp_d, e < 4, e == 4);
      end
    end
    load1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_launch();
    test_pending_overrun();
    test_preempt();
    test_load_at_expiry();
    test_reset_mid_hold();
    test_equal_value();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
